// File: rtl/exu_lsu_pkg.sv
// Shared types and helpers for the execution-stage load/store unit:
// access size encoding, the outstanding-transaction tracker entry, and
// the pure lane-steering / extension functions used by exu_lsu.
package exu_lsu_pkg;

   // Access size encoding on req_size_i (3 is illegal and rejected)
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_X = 2'd3;

   // One granted transaction awaiting its rvalid: everything the response
   // path needs to steer, extend and tag the returned data.
   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       sgn;
      logic [1:0] off;
      logic [4:0] rd;
   } lsu_trk_t;

   localparam int TRK_W = $bits(lsu_trk_t);

   // Byte enables for an aligned access of the given size at byte offset off
   function automatic logic [3:0] be_gen(input logic [1:0] size,
                                         input logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_B:    be = 4'b0001 << off;
         SZ_H:    be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // True when the access cannot be served by a single aligned bus word
   function automatic logic misaligned_chk(input logic [1:0] size,
                                           input logic [1:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off != 2'd0);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Replicate the low store bits over every lane so be alone picks the target
   function automatic logic [31:0] wdata_gen(input logic [1:0]  size,
                                             input logic [31:0] wdata);
      logic [31:0] w;
      case (size)
         SZ_B:    w = {4{wdata[7:0]}};
         SZ_H:    w = {2{wdata[15:0]}};
         default: w = wdata;
      endcase
      return w;
   endfunction

   // Move the addressed lane down to bit 0, then sign- or zero-extend
   function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                input logic [1:0]  size,
                                                input logic        sgn,
                                                input logic [1:0]  off);
      logic [31:0] sh;
      logic [31:0] res;
      sh = rdata >> {off, 3'b000};
      case (size)
         SZ_B:    res = {{24{sgn & sh[7]}}, sh[7:0]};
         SZ_H:    res = {{16{sgn & sh[15]}}, sh[15:0]};
         default: res = rdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_trk_fifo.sv
// Generic DEPTH-entry FIFO used to remember granted bus transactions in
// order until their responses come back. DEPTH need not be a power of two;
// pointers wrap explicitly. Push at full and pop at empty are ignored.
module lsu_trk_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Entry storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/exu_lsu.sv
// Pipelined load/store unit. A registered issue slot drives the req/gnt
// bus; granted transactions are remembered in lsu_trk_fifo until their
// rvalid arrives, at which point load data is steered, extended and
// written back tagged with rd (or a store completion is pulsed).
//
// Handshake: a request transfers on req_valid_i & req_ready_o & ~kill_i.
// The bus transfers on mem_req_o & mem_gnt_i; once granted, a transaction
// is never withdrawn. Responses (mem_rvalid_i) return in grant order.
module exu_lsu
   import exu_lsu_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int WB_REG = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [4:0]  req_rd_i,
   input  logic        kill_i,
   output logic        misaligned_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o,
   output logic        store_done_o,
   output logic        busy_o,
   output logic        proto_err_o
);

   localparam int CW = $clog2(DEPTH + 1);

   // Issue slot
   logic        issue_valid;
   logic [31:0] issue_addr;
   logic [3:0]  issue_be;
   logic [31:0] issue_wdata;
   lsu_trk_t    issue_ent;

   // Tracker view
   logic [TRK_W-1:0] trk_head_raw;
   lsu_trk_t         trk_head;
   logic             trk_full;
   logic             trk_empty;
   logic [CW-1:0]    trk_count;

   logic        accept;
   logic        req_mis;
   logic        fire;
   logic        rsp_pop;
   logic [31:0] rsp_data;

   // Full gates the request even when a pop lands in the same cycle, so the
   // tracker never sees a push at full.
   assign mem_req_o    = issue_valid & ~trk_full;
   assign fire         = mem_req_o & mem_gnt_i;
   assign req_ready_o  = ~issue_valid | fire;
   assign accept       = req_valid_i & req_ready_o & ~kill_i;
   assign req_mis      = misaligned_chk(req_size_i, req_addr_i[1:0]);
   assign misaligned_o = accept & req_mis;

   assign mem_addr_o   = issue_addr;
   assign mem_we_o     = issue_ent.we;
   assign mem_be_o     = issue_be;
   assign mem_wdata_o  = issue_wdata;

   assign busy_o       = issue_valid | (trk_count != '0);

   // Issue slot: load on a good accept, free on grant or on kill when ungranted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         issue_addr  <= '0;
         issue_be    <= '0;
         issue_wdata <= '0;
         issue_ent   <= '0;
      end else if (accept && !req_mis) begin
         issue_valid    <= 1'b1;
         issue_addr     <= {req_addr_i[31:2], 2'b00};
         issue_be       <= be_gen(req_size_i, req_addr_i[1:0]);
         issue_wdata    <= wdata_gen(req_size_i, req_wdata_i);
         issue_ent.we   <= req_we_i;
         issue_ent.size <= req_size_i;
         issue_ent.sgn  <= req_signed_i;
         issue_ent.off  <= req_addr_i[1:0];
         issue_ent.rd   <= req_rd_i;
      end else if (fire || kill_i) begin
         issue_valid <= 1'b0;
      end
   end

   lsu_trk_fifo #(
      .DEPTH (DEPTH),
      .W     (TRK_W)
   ) u_trk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fire),
      .din   (issue_ent),
      .pop   (rsp_pop),
      .dout  (trk_head_raw),
      .full  (trk_full),
      .empty (trk_empty),
      .count (trk_count)
   );

   assign trk_head = lsu_trk_t'(trk_head_raw);
   assign rsp_pop  = mem_rvalid_i & ~trk_empty;
   assign rsp_data = load_extract(mem_rdata_i, trk_head.size, trk_head.sgn,
                                  trk_head.off);

   // Sticky protocol error: a response arrived with nothing outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         proto_err_o <= 1'b0;
      else if (mem_rvalid_i && trk_empty) proto_err_o <= 1'b1;
   end

   generate
      if (WB_REG != 0) begin : g_wb_reg
         logic        wb_valid_q;
         logic        store_done_q;
         logic [4:0]  wb_rd_q;
         logic [31:0] wb_data_q;

         // Registered writeback: one cycle after the response
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wb_valid_q   <= 1'b0;
               store_done_q <= 1'b0;
               wb_rd_q      <= '0;
               wb_data_q    <= '0;
            end else begin
               wb_valid_q   <= rsp_pop & ~trk_head.we;
               store_done_q <= rsp_pop & trk_head.we;
               if (rsp_pop && !trk_head.we) begin
                  wb_rd_q   <= trk_head.rd;
                  wb_data_q <= rsp_data;
               end
            end
         end

         assign wb_valid_o   = wb_valid_q;
         assign store_done_o = store_done_q;
         assign wb_rd_o      = wb_rd_q;
         assign wb_data_o    = wb_data_q;
      end else begin : g_wb_comb
         // Combinational writeback in the response cycle; quiet otherwise
         assign wb_valid_o   = rsp_pop & ~trk_head.we;
         assign store_done_o = rsp_pop & trk_head.we;
         assign wb_rd_o      = wb_valid_o ? trk_head.rd : 5'd0;
         assign wb_data_o    = wb_valid_o ? rsp_data : 32'd0;
      end
   endgenerate

endmodule

// File: tb/tb_exu_lsu.sv
// Bench for exu_lsu (DEPTH=2, WB_REG=1): directed access sequences with
// literal expectations, plus a transaction-level model checked every cycle.
module tb_exu_lsu;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic        req_signed_i;
   logic [4:0]  req_rd_i;
   logic        kill_i;
   logic        misaligned_o;
   logic        mem_req_o;
   logic        mem_gnt_i;
   logic [31:0] mem_addr_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic        store_done_o;
   logic        busy_o;
   logic        proto_err_o;

   exu_lsu #(.DEPTH(DEPTH), .WB_REG(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_we_i     (req_we_i),
      .req_size_i   (req_size_i),
      .req_signed_i (req_signed_i),
      .req_rd_i     (req_rd_i),
      .kill_i       (kill_i),
      .misaligned_o (misaligned_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_addr_o   (mem_addr_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .wb_valid_o   (wb_valid_o),
      .wb_rd_o      (wb_rd_o),
      .wb_data_o    (wb_data_o),
      .store_done_o (store_done_o),
      .busy_o       (busy_o),
      .proto_err_o  (proto_err_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit we;
      int size;
      bit sgn;
      int off;
      int rd;
   } txn_t;

   txn_t        m_trk[$];
   txn_t        m_slot;
   txn_t        m_pop;
   bit          m_slot_v;
   logic [31:0] m_slot_addr;
   logic [31:0] m_slot_wdata;
   bit          m_perr;
   bit          m_wb_v;
   bit          m_sd;
   logic [4:0]  m_wb_rd;
   logic [31:0] m_wb_data;
   bit          e_full, e_req, e_fire, e_ready, e_acc, e_mis, e_pop;

   function automatic bit f_mis(input int size, input logic [31:0] addr);
      if (size == 3) return 1'b1;
      return (addr % (32'd1 << size)) != 0;
   endfunction

   function automatic logic [3:0] f_be(input int size, input int off);
      int n = 1 << size;
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] f_wdata(input int size, input logic [31:0] w);
      logic [31:0] r;
      int n = 1 << size;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] f_load(input txn_t t, input logic [31:0] rdata);
      int n = 1 << t.size;
      logic [31:0] v;
      logic [31:0] mask;
      v = rdata >> (8 * t.off);
      if (n < 4) begin
         mask = (32'h1 << (8 * n)) - 1;
         v = v & mask;
         if (t.sgn && v[8*n-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // Compare process: outputs against the model each cycle, then advance it
   always @(negedge clk) begin
      if (!rst_n) begin
         m_trk.delete();
         m_slot_v = 0;
         m_perr   = 0;
         m_wb_v   = 0;
         m_sd     = 0;
      end else begin
         e_full  = (m_trk.size() == DEPTH);
         e_req   = m_slot_v && !e_full;
         e_fire  = e_req && mem_gnt_i;
         e_ready = !m_slot_v || e_fire;
         e_acc   = req_valid_i && e_ready && !kill_i;
         e_mis   = e_acc && f_mis(int'(req_size_i), req_addr_i);

         chk("m_ready", req_ready_o, e_ready);
         chk("m_misaligned", misaligned_o, e_mis);
         chk("m_mem_req", mem_req_o, e_req);
         if (e_req) begin
            chk("m_mem_addr", mem_addr_o, m_slot_addr & 32'hFFFF_FFFC);
            chk("m_mem_we", mem_we_o, m_slot.we);
            chk("m_mem_be", mem_be_o, f_be(m_slot.size, m_slot.off));
            chk("m_mem_wdata", mem_wdata_o, f_wdata(m_slot.size, m_slot_wdata));
         end
         chk("m_wb_valid", wb_valid_o, m_wb_v);
         if (m_wb_v) begin
            chk("m_wb_rd", wb_rd_o, m_wb_rd);
            chk("m_wb_data", wb_data_o, m_wb_data);
         end
         chk("m_store_done", store_done_o, m_sd);
         chk("m_busy", busy_o, m_slot_v || (m_trk.size() != 0));
         chk("m_proto_err", proto_err_o, m_perr);

         e_pop = mem_rvalid_i && (m_trk.size() != 0);
         if (mem_rvalid_i && m_trk.size() == 0) m_perr = 1;
         m_wb_v = 0;
         m_sd   = 0;
         if (e_pop) begin
            m_pop = m_trk.pop_front();
            if (m_pop.we) m_sd = 1;
            else begin
               m_wb_v    = 1;
               m_wb_rd   = 5'(m_pop.rd);
               m_wb_data = f_load(m_pop, mem_rdata_i);
            end
         end
         if (e_fire) m_trk.push_back(m_slot);
         if (e_acc && !e_mis) begin
            m_slot_v      = 1;
            m_slot.we     = req_we_i;
            m_slot.size   = int'(req_size_i);
            m_slot.sgn    = req_signed_i;
            m_slot.off    = int'(req_addr_i % 4);
            m_slot.rd     = int'(req_rd_i);
            m_slot_addr   = req_addr_i;
            m_slot_wdata  = req_wdata_i;
         end else if (e_fire || kill_i) begin
            m_slot_v = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req_valid_i  = 1'b0;
      kill_i       = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
   endtask

   task automatic set_req(input logic [31:0] addr, input logic [1:0] size,
                          input logic we, input logic sgn, input logic [4:0] rd,
                          input logic [31:0] wdata);
      req_valid_i  = 1'b1;
      req_addr_i   = addr;
      req_size_i   = size;
      req_we_i     = we;
      req_signed_i = sgn;
      req_rd_i     = rd;
      req_wdata_i  = wdata;
   endtask

   // Accept in N, grant in N+1, rvalid in N+2, writeback checked in N+3
   task automatic do_load(input string nm, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
      step(); idle_in(); set_req(addr, size, 1'b0, sgn, rd, 32'h0);
      @(negedge clk); chk({nm, "_ready"}, req_ready_o, 1);
      step(); idle_in(); mem_gnt_i = 1'b1;
      @(negedge clk); chk({nm, "_req"}, mem_req_o, 1); chk({nm, "_be"}, mem_be_o, exp_be);
      step(); idle_in(); mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
      @(negedge clk); chk({nm, "_wb_early"}, wb_valid_o, 0);
      step(); idle_in();
      @(negedge clk);
      chk({nm, "_wb_valid"}, wb_valid_o, 1);
      chk({nm, "_wb_data"}, wb_data_o, exp_data);
      chk({nm, "_wb_rd"}, wb_rd_o, rd);
   endtask

   task automatic do_store(input string nm, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      step(); idle_in(); set_req(addr, size, 1'b1, 1'b0, 5'd0, wdata);
      step(); idle_in(); mem_gnt_i = 1'b1;
      @(negedge clk);
      chk({nm, "_be"}, mem_be_o, exp_be);
      chk({nm, "_wdata"}, mem_wdata_o, exp_wdata);
      chk({nm, "_we"}, mem_we_o, 1);
      step(); idle_in(); mem_rvalid_i = 1'b1;
      step(); idle_in();
      @(negedge clk);
      chk({nm, "_done"}, store_done_o, 1);
      chk({nm, "_no_wb"}, wb_valid_o, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0;
      idle_in();
      set_req(32'h0, 2'd0, 1'b0, 1'b0, 5'd0, 32'h0);
      req_valid_i = 1'b0;
      @(negedge clk);
      chk("rst_ready", req_ready_o, 1);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_wb_valid", wb_valid_o, 0);
      chk("rst_proto", proto_err_o, 0);
      chk("rst_be", mem_be_o, 0);
      step(); step();
      rst_n = 1'b1;

      // Loads: lane steering and extension
      do_load("lw",  32'h1004, 2'd2, 1'b0, 5'd5,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
      do_load("lb",  32'h1003, 2'd0, 1'b1, 5'd7,  32'h80FF0000, 4'h8, 32'hFFFFFF80);
      do_load("lbu", 32'h1003, 2'd0, 1'b0, 5'd7,  32'h80FF0000, 4'h8, 32'h00000080);
      do_load("lh",  32'h1002, 2'd1, 1'b1, 5'd12, 32'h80010000, 4'hC, 32'hFFFF8001);
      do_load("lhu", 32'h1000, 2'd1, 1'b0, 5'd13, 32'h1234F00F, 4'h3, 32'h0000F00F);

      // Stores: byte enables and lane replication
      do_store("sb", 32'h2002, 2'd0, 32'h000000A5, 4'h4, 32'hA5A5A5A5);
      do_store("sh", 32'h2002, 2'd1, 32'hBEEF1234, 4'hC, 32'h12341234);
      do_store("sw", 32'h2000, 2'd2, 32'h01234567, 4'hF, 32'h01234567);

      // Tracker full: third load waits in the slot
      step(); idle_in(); set_req(32'h100, 2'd2, 1'b0, 1'b0, 5'd1, 32'h0); mem_gnt_i = 1'b1;
      step(); idle_in(); set_req(32'h104, 2'd2, 1'b0, 1'b0, 5'd2, 32'h0); mem_gnt_i = 1'b1;
      @(negedge clk); chk("full_req1", mem_req_o, 1);
      step(); idle_in(); set_req(32'h108, 2'd2, 1'b0, 1'b0, 5'd3, 32'h0); mem_gnt_i = 1'b1;
      @(negedge clk); chk("full_req2", mem_req_o, 1);
      step(); idle_in(); mem_gnt_i = 1'b1;
      @(negedge clk); chk("full_req_gated", mem_req_o, 0); chk("full_not_ready", req_ready_o, 0);
      step(); idle_in(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
      @(negedge clk); chk("full_gated_on_pop", mem_req_o, 0);
      step(); idle_in(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22222222;
      @(negedge clk); chk("full_release", mem_req_o, 1); chk("full_rd1", wb_rd_o, 1);
      step(); idle_in(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33333333;
      @(negedge clk); chk("full_rd2", wb_rd_o, 2);
      step(); idle_in();
      @(negedge clk); chk("full_rd3", wb_rd_o, 3); chk("full_data3", wb_data_o, 32'h33333333);

      // Misaligned rejections
      step(); idle_in(); set_req(32'h2001, 2'd1, 1'b1, 1'b0, 5'd0, 32'h0);
      @(negedge clk); chk("mis_sh_pulse", misaligned_o, 1); chk("mis_sh_noreq", mem_req_o, 0);
      step(); idle_in();
      @(negedge clk); chk("mis_sh_busy", busy_o, 0); chk("mis_sh_req_after", mem_req_o, 0);
      step(); idle_in(); set_req(32'h1002, 2'd2, 1'b0, 1'b0, 5'd4, 32'h0);
      @(negedge clk); chk("mis_lw_pulse", misaligned_o, 1);
      step(); idle_in(); set_req(32'h1000, 2'd3, 1'b0, 1'b0, 5'd4, 32'h0);
      @(negedge clk); chk("mis_sz3_pulse", misaligned_o, 1);
      step(); idle_in();

      // kill with gnt low: slot dropped, nothing comes back
      step(); idle_in(); set_req(32'h300, 2'd2, 1'b0, 1'b0, 5'd8, 32'h0);
      step(); idle_in(); kill_i = 1'b1;
      @(negedge clk); chk("kill0_req", mem_req_o, 1);
      step(); idle_in();
      @(negedge clk); chk("kill0_busy", busy_o, 0); chk("kill0_noreq", mem_req_o, 0);
      step(); idle_in(); step(); idle_in();

      // kill with gnt high: granted load still written back; new request blocked
      step(); idle_in(); set_req(32'h304, 2'd2, 1'b0, 1'b0, 5'd9, 32'h0);
      step(); idle_in(); kill_i = 1'b1; mem_gnt_i = 1'b1;
      set_req(32'h400, 2'd2, 1'b0, 1'b0, 5'd10, 32'h0); kill_i = 1'b1;
      step(); idle_in(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
      @(negedge clk); chk("kill1_blocked", mem_req_o, 0); chk("kill1_busy", busy_o, 1);
      step(); idle_in();
      @(negedge clk);
      chk("kill1_wb", wb_valid_o, 1);
      chk("kill1_rd", wb_rd_o, 9);
      chk("kill1_data", wb_data_o, 32'hCAFEF00D);

      // Back-to-back throughput: one access per cycle, tracker never full
      for (int i = 0; i < 9; i++) begin
         step(); idle_in();
         if (i < 6) set_req(32'h500 + 32'(4 * i), 2'd2, 1'b0, 1'b0, 5'(11 + i), 32'h0);
         mem_gnt_i = 1'b1;
         if (i >= 2 && i < 8) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hA000_0000 + 32'(i);
         end
         if (i < 6) begin
            @(negedge clk); chk("b2b_ready", req_ready_o, 1);
         end
      end
      step(); idle_in();

      // Response with nothing outstanding
      step(); idle_in(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555AAAA;
      @(negedge clk); chk("proto_pre", proto_err_o, 0);
      step(); idle_in();
      @(negedge clk); chk("proto_set", proto_err_o, 1); chk("proto_no_wb", wb_valid_o, 0);
      step(); idle_in();
      @(negedge clk); chk("proto_sticky", proto_err_o, 1);

      // Reset mid-operation clears slot, tracker and the sticky error
      step(); idle_in(); set_req(32'h600, 2'd2, 1'b0, 1'b0, 5'd20, 32'h0);
      step(); idle_in(); mem_gnt_i = 1'b1; set_req(32'h604, 2'd2, 1'b0, 1'b0, 5'd21, 32'h0);
      step(); idle_in(); rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_busy", busy_o, 0);
      chk("mrst_ready", req_ready_o, 1);
      chk("mrst_proto", proto_err_o, 0);
      step(); step();
      rst_n = 1'b1;
      step(); idle_in();
      @(negedge clk); chk("mrst_idle", busy_o, 0);

      // Post-reset sanity load
      do_load("lw2", 32'h0008, 2'd2, 1'b0, 5'd31, 32'h0BADF00D, 4'hF, 32'h0BADF00D);
      step(); idle_in(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
